nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl_if.sv | 35 +++
 rtl/nibble_serial_add_ctrl.sv | 135 +++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl; ovf exists only with OVF_FLAG_EN.
interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef OVF_FLAG_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef OVF_FLAG_EN
    , ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef OVF_FLAG_EN
    , ovf
`endif
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Serial W-bit adder on one 4-bit ripple adder: result valid NIBBLES cycles after accept, held until out_ready.
// OVF_FLAG_EN adds a registered signed-overflow flag; no input reaches an output combinationally.
module multibitrippleadder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic r_c;

  always_comb begin
    o_sum = '0;
    r_c   = i_cin;
    for (int i = 0; i < 4; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ r_c;
      r_c      = (i_a[i] & i_b[i]) | (r_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = r_c;
  end
endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  nibble_serial_add_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [IW-1:0] r_idx;
`ifdef OVF_FLAG_EN
  logic          r_ovf;
`endif

  logic [IW+1:0] w_base;
  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [3:0]    w_nsum;
  logic          w_ncout;
  logic          w_last;
  logic          w_accept;
  logic          w_release;

  assign w_base    = {r_idx, 2'b00};
  assign w_a_nib   = r_a[w_base +: 4];
  assign w_b_nib   = r_b[w_base +: 4];
  assign w_last    = (r_idx == IW'(NIBBLES - 1));
  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_release = (r_state == DONE) && bus.out_ready;

  multibitrippleadder u_add (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_nsum),
    .o_cout (w_ncout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (w_release) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
`ifdef OVF_FLAG_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_carry <= bus.cin;
        r_idx   <= '0;
        r_sum   <= '0;
`ifdef OVF_FLAG_EN
        r_ovf   <= 1'b0;
`endif
      end
      if (r_state == RUN) begin
        r_sum[w_base +: 4] <= w_nsum;
        r_carry            <= w_ncout;
        // idx parks on the last nibble rather than wrapping
        if (w_last) begin
          r_cout <= w_ncout;
`ifdef OVF_FLAG_EN
          r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_nsum[3] != r_a[W-1]);
`endif
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
`ifdef OVF_FLAG_EN
  assign bus.ovf       = r_ovf;
`endif
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl (NIBBLES=4): directed corner cases plus random traffic.
module tb_nibble_serial_add_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_pass;
  int   rmode;
  bit   b2b;
  bit   b2b_seen;
  int   last_acc;
  bit   prev_ov;
  bit   prev_hs;
  exp_t exp_q[$];

  nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int acc);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    e.acc  = acc;
    return e;
  endfunction

  // out_ready: 0 = held low, 1 = held high, 2 = random
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_ov  = 1'b0;
      prev_hs  = 1'b0;
      b2b_seen = 1'b0;
    end else begin
      chk("valid_ready_exclusive", bus.out_valid && bus.in_ready, 1'b0);
      if (prev_hs) chk("in_ready_after_release", bus.in_ready, 1'b1);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.cin, cyc + 1));
        if (b2b) begin
          if (b2b_seen) chk("initiation_interval", 64'(cyc + 1 - last_acc), 64'(N + 2));
          b2b_seen = 1'b1;
          last_acc = cyc + 1;
        end else begin
          b2b_seen = 1'b0;
        end
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: sum %0h with no request outstanding", bus.sum);
        end else begin
          if (!prev_ov) chk("latency", 64'(cyc - exp_q[0].acc), 64'(N));
          chk("sum", bus.sum, exp_q[0].sum);
          chk("cout", bus.cout, exp_q[0].cout);
`ifdef OVF_FLAG_EN
          chk("ovf", bus.ovf, exp_q[0].ovf);
`endif
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      prev_hs = bus.out_valid && bus.out_ready;
      prev_ov = bus.out_valid;
    end
  end

  // Caller sits just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    bus.a = a; bus.b = b; bus.cin = c; bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) timeout("in_ready_wait");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_sum"}, bus.sum, '0);
    chk({tag, "_cout"}, bus.cout, 1'b0);
`ifdef OVF_FLAG_EN
    chk({tag, "_ovf"}, bus.ovf, 1'b0);
`endif
  endtask

  initial begin
    int n;
    n_chk = 0; n_pass = 0; cyc = 0; rmode = 1; b2b = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;

    issue(16'h1234, 16'h4321, 1'b0);
    issue(16'h0FFF, 16'hF000, 1'b1);
    issue(16'h7FFF, 16'h0001, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0);
    issue(16'h8000, 16'h8000, 1'b0);
    drain();

    // Backpressure: result held while new operands are waved at the input
    rmode = 0;
    issue(16'hABCD, 16'h1357, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    if (!bus.out_valid) timeout("out_valid_wait");
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rmode = 1;
    issue(16'h0F0F, 16'h00F1, 1'b0);
    drain();

    // Abort once idx has reached 2
    issue(16'h5555, 16'h2222, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    repeat (10) @(posedge clk);
    #1;

    b2b = 1'b1;
    issue(16'h1111, 16'h2222, 1'b0);
    issue(16'hF00F, 16'h0FF1, 1'b1);
    issue(16'h8001, 16'hFFFF, 1'b1);
    drain();
    b2b = 1'b0;

    rmode = 2;
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rmode = 1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
